// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: control-word bit map, opcodes and fetch words for the bus CPU sequencer
package control_sequencer_pkg;
  localparam int B_HLT = 15, B_MI = 14, B_RI = 13, B_RO = 12, B_IO = 11, B_II = 10, B_AI = 9, B_AO = 8;
  localparam int B_EO = 7, B_SU = 6, B_BI = 5, B_OI = 4, B_CE = 3, B_CO = 2, B_J = 1, B_FI = 0;
  localparam logic [15:0] C_HLT = 16'(1) << B_HLT;
  localparam logic [15:0] C_MI = 16'(1) << B_MI;
  localparam logic [15:0] C_RI = 16'(1) << B_RI;
  localparam logic [15:0] C_RO = 16'(1) << B_RO;
  localparam logic [15:0] C_IO = 16'(1) << B_IO;
  localparam logic [15:0] C_II = 16'(1) << B_II;
  localparam logic [15:0] C_AI = 16'(1) << B_AI;
  localparam logic [15:0] C_AO = 16'(1) << B_AO;
  localparam logic [15:0] C_EO = 16'(1) << B_EO;
  localparam logic [15:0] C_SU = 16'(1) << B_SU;
  localparam logic [15:0] C_BI = 16'(1) << B_BI;
  localparam logic [15:0] C_OI = 16'(1) << B_OI;
  localparam logic [15:0] C_CE = 16'(1) << B_CE;
  localparam logic [15:0] C_CO = 16'(1) << B_CO;
  localparam logic [15:0] C_J = 16'(1) << B_J;
  localparam logic [15:0] C_FI = 16'(1) << B_FI;
  localparam logic [15:0] CTRL_FETCH0 = C_CO | C_MI;
  localparam logic [15:0] CTRL_FETCH1 = C_RO | C_II | C_CE;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC = 4'h7,
    OP_JZ = 4'h8, OP_OUT = 4'he, OP_HLT = 4'hf
  } opcode_e;
endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// microcode_rom: combinational (opcode, step, flags) -> control word lookup
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] word
);
  always_comb begin
    word = '0;
    if (step == 3'd0) word = CTRL_FETCH0;
    else if (step == 3'd1) word = CTRL_FETCH1;
    else
      case (opcode_e'(opcode))
        OP_LDA: word = step == 3'd2 ? C_IO | C_MI : step == 3'd3 ? C_RO | C_AI : '0;
        OP_ADD, OP_SUB: word = step == 3'd2 ? C_IO | C_MI : step == 3'd3 ? C_RO | C_BI :
                               step == 3'd4 ? C_EO | C_AI | C_FI | (opcode == OP_SUB ? C_SU : '0) : '0;
        OP_STA: word = step == 3'd2 ? C_IO | C_MI : step == 3'd3 ? C_AO | C_RI : '0;
        OP_LDI: word = step == 3'd2 ? C_IO | C_AI : '0;
        OP_JMP: word = step == 3'd2 ? C_IO | C_J : '0;
        OP_JC:  word = step == 3'd2 && flag_c ? C_IO | C_J : '0;
        OP_JZ:  word = step == 3'd2 && flag_z ? C_IO | C_J : '0;
        OP_OUT: word = step == 3'd2 ? C_AO | C_OI : '0;
        OP_HLT: word = step == 3'd2 ? C_HLT : '0;
        default: word = '0;
      endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state counter with early end, sticky halt and forced-zero reset output
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);
  logic [2:0]  step_q, step_d, step_nx;
  logic        halted_q, halted_d;
  logic [15:0] word_cur, word_nxt;
  assign step_nx = step_q + 3'd1;
  microcode_rom u_rom_cur (.opcode(opcode), .step(step_q), .flag_c(flag_c), .flag_z(flag_z), .word(word_cur));
  // Look-ahead copy lets the counter skip trailing empty microsteps
  microcode_rom u_rom_nxt (.opcode(opcode), .step(step_nx), .flag_c(flag_c), .flag_z(flag_z), .word(word_nxt));
  always_comb begin
    halted_d = halted_q | word_cur[B_HLT];
    step_d = halted_d ? step_q :
             step_q == 3'(NUM_STEPS - 1) ? 3'd0 :
             EARLY_END && step_q >= 3'd2 && word_nxt == '0 ? 3'd0 : step_nx;
    ctrl = !clear_n ? '0 : halted_q ? C_HLT : word_cur;
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  assign step = step_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of two sequencers (early end on/off) against a table model
module tb_control_sequencer;
  localparam int N = 5;
  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE = 16'h0008, CO = 16'h0004, J = 16'h0002, FI = 16'h0001;
  logic clk = 1'b0, clear_n = 1'b0;
  logic [3:0] op1 = '0, op0 = '0;
  logic c1 = 1'b0, z1 = 1'b0, c0 = 1'b0, z0 = 1'b0;
  logic [15:0] ctrl1, ctrl0;
  logic [2:0] step1, step0;
  logic h1, h0;
  int checks = 0, errors = 0;
  int s1 = 0, s0 = 0;
  bit hm1 = 1'b0, hm0 = 1'b0;
  always #5 clk = ~clk;
  control_sequencer #(.NUM_STEPS(N), .EARLY_END(1'b1)) dut (
    .clk(clk), .clear_n(clear_n), .opcode(op1), .flag_c(c1), .flag_z(z1),
    .ctrl(ctrl1), .step(step1), .halted(h1));
  control_sequencer #(.NUM_STEPS(N), .EARLY_END(1'b0)) dut_full (
    .clk(clk), .clear_n(clear_n), .opcode(op0), .flag_c(c0), .flag_z(z0),
    .ctrl(ctrl0), .step(step0), .halted(h0));
  function automatic logic [15:0] word(input logic [3:0] op, input int s, input logic c, input logic z);
    logic [15:0] t [3];
    if (s == 0) return CO | MI;
    if (s == 1) return RO | II | CE;
    if (s > 4) return '0;
    case (op)
      4'h1: t = '{IO | MI, RO | AI, 16'h0};
      4'h2: t = '{IO | MI, RO | BI, EO | AI | FI};
      4'h3: t = '{IO | MI, RO | BI, EO | AI | FI | SU};
      4'h4: t = '{IO | MI, AO | RI, 16'h0};
      4'h5: t = '{IO | AI, 16'h0, 16'h0};
      4'h6: t = '{IO | J, 16'h0, 16'h0};
      4'h7: t = '{c ? IO | J : 16'h0, 16'h0, 16'h0};
      4'h8: t = '{z ? IO | J : 16'h0, 16'h0, 16'h0};
      4'he: t = '{AO | OI, 16'h0, 16'h0};
      4'hf: t = '{HLT, 16'h0, 16'h0};
      default: t = '{16'h0, 16'h0, 16'h0};
    endcase
    return t[s-2];
  endfunction
  function automatic int ilen(input logic [3:0] op, input logic c, input logic z, input bit ee);
    int l = 3;
    if (!ee) return N;
    for (int s = 2; s < N; s++) if (word(op, s, c, z) != '0) l = s + 1;
    return l;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("ctrl_ee", ctrl1, hm1 ? HLT : word(op1, s1, c1, z1));
    chk("step_ee", 16'(step1), 16'(s1));
    chk("halt_ee", 16'(h1), 16'(hm1));
    chk("ctrl_full", ctrl0, hm0 ? HLT : word(op0, s0, c0, z0));
    chk("step_full", 16'(step0), 16'(s0));
    chk("halt_full", 16'(h0), 16'(hm0));
  endtask
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    if (!hm1) begin
      if (word(op1, s1, c1, z1) & HLT) hm1 = 1'b1;
      else s1 = (s1 + 1 == ilen(op1, c1, z1, 1'b1)) ? 0 : s1 + 1;
    end
    if (!hm0) begin
      if (word(op0, s0, c0, z0) & HLT) hm0 = 1'b1;
      else s0 = (s0 + 1 == ilen(op0, c0, z0, 1'b0)) ? 0 : s0 + 1;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 clear_n = 1'b0;
    #1;
    chk("rst_ctrl_ee", ctrl1, 16'h0);
    chk("rst_step_ee", 16'(step1), 16'h0);
    chk("rst_halt_ee", 16'(h1), 16'h0);
    chk("rst_ctrl_full", ctrl0, 16'h0);
    chk("rst_step_full", 16'(step0), 16'h0);
    s1 = 0; s0 = 0; hm1 = 1'b0; hm0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_step", 16'(step1), 16'h0);
    chk("rst_hold_ctrl", ctrl1, 16'h0);
    clear_n = 1'b1;
    #1 chk("rel_t0", ctrl1, CO | MI);
    #1;
  endtask
  task automatic load(input logic [3:0] op, input logic c, input logic z);
    int n = 0;
    while (!((s1 == 0 || hm1) && (s0 == 0 || hm0)) && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) chk("sync_timeout", 16'(n), 16'h0);
    op1 = op; c1 = c; z1 = z;
    op0 = op; c0 = c; z0 = z;
  endtask
  function automatic logic [3:0] rand_op();
    logic [3:0] op = 4'($urandom_range(0, 15));
    if (op == 4'hf && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 14));
    return op;
  endfunction
  initial begin
    @(negedge clk);
    do_reset();
    load(4'h1, 1'b0, 1'b0);
    repeat (4) cycle();
    chk("lda_wrap_step", 16'(step1), 16'h0);
    load(4'h3, 1'b0, 1'b0);
    repeat (4) cycle();
    chk("sub_t4_step", 16'(step1), 16'h4);
    chk("sub_t4_ctrl", ctrl1, EO | AI | SU | FI);
    load(4'h7, 1'b0, 1'b0);
    repeat (2) cycle();
    chk("jc_nt_t2", ctrl1, 16'h0);
    repeat (2) cycle();
    load(4'h7, 1'b1, 1'b0);
    repeat (2) cycle();
    chk("jc_t_t2", ctrl1, IO | J);
    load(4'h5, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("ldi_full_t3", ctrl0, 16'h0);
    load(4'hf, 1'b0, 1'b0);
    repeat (25) cycle();
    chk("hlt_step", 16'(step1), 16'h2);
    chk("hlt_flag", 16'(h1), 16'h1);
    chk("hlt_ctrl", ctrl1, HLT);
    do_reset();
    load(4'h2, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("add_t3", ctrl1, RO | BI);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0 || (hm1 && hm0)) do_reset();
      if (s1 == 0 || hm1) begin
        op1 = rand_op(); c1 = 1'($urandom); z1 = 1'($urandom);
      end
      if (s0 == 0 || hm0) begin
        op0 = rand_op(); c0 = 1'($urandom); z0 = 1'($urandom);
      end
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
